// File: rtl/stopwatch_pkg.sv
// Shared state encodings for the stopwatch run/pause/clear/lap sequencer.
// The values are also what drives the board LEDs.
// No logic here.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Purpose: brings a debounced async button level into clk and flags its rising edge.
// Latency: edge_o is high in the second cycle after the level is first sampled.
// Backpressure: none; every rising edge yields exactly one single-cycle pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_o
);

  logic s1;
  logic s2;
  logic s3;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_o = s2 & ~s3;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose: run/pause/clear/lap sequencer and 1 Hz tick generator for the BCD seconds counter.
// Latency: a button level change shows up as a state change two cycles after it is first sampled.
// Backpressure: none; button edges are acted on immediately, clear has top priority.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  // 1: halt with alarm when the counter wraps 99->00; 0: keep counting
  parameter bit STOP_AT_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run,
  input  logic               btn_clear,
  input  logic               btn_lap,
  input  logic [3:0]         cnt_digit_l,
  input  logic [3:0]         cnt_digit_h,
  input  logic               cnt_overflow,
  output logic               cnt_rst,
  output logic               cnt_clk_1hz,
  output logic               cnt_start,
  output logic               cnt_pause,
  output logic [3:0]         lap_l,
  output logic [3:0]         lap_h,
  output logic               lap_valid,
  output logic               alarm,
  output logic [STATE_W-1:0] state
);

  // DIV is expected to be even and at least 4 so the tick has a clean 50% duty.
  localparam int            DIV     = CLK_HZ / TICK_HZ;
  localparam int            PW      = $clog2(DIV);
  localparam logic [PW-1:0] PS_MAX  = PW'(DIV - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(DIV / 2);

  state_t        cur_st;
  state_t        nxt_st;
  logic [PW-1:0] presc;
  logic          run_edge;
  logic          clear_edge;
  logic          lap_edge;

  btn_sync_edge u_sync_run   (.clk(clk), .rst(rst), .din(btn_run),   .edge_o(run_edge));
  btn_sync_edge u_sync_clear (.clk(clk), .rst(rst), .din(btn_clear), .edge_o(clear_edge));
  btn_sync_edge u_sync_lap   (.clk(clk), .rst(rst), .din(btn_lap),   .edge_o(lap_edge));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Next-state selection and counter-control decode; clear overrides everything.
  always_comb begin
    nxt_st    = cur_st;
    cnt_rst   = 1'b0;
    cnt_start = 1'b0;
    cnt_pause = 1'b0;
    alarm     = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        cnt_rst = 1'b1;
        if (run_edge) nxt_st = ST_RUN;
      end
      ST_RUN: begin
        cnt_start = 1'b1;
        // Overflow wins over a simultaneous run press.
        if (cnt_overflow && STOP_AT_WRAP) nxt_st = ST_DONE;
        else if (run_edge)                nxt_st = ST_PAUSE;
      end
      ST_PAUSE: begin
        cnt_start = 1'b1;
        cnt_pause = 1'b1;
        if (run_edge) nxt_st = ST_RUN;
      end
      ST_DONE: begin
        cnt_start = 1'b1;
        cnt_pause = 1'b1;
        alarm     = 1'b1;
      end
      default: nxt_st = ST_IDLE;
    endcase
    if (clear_edge) nxt_st = ST_IDLE;
  end

  // Tick prescaler: counts only in RUN, so PAUSE/DONE keep the partial second.
  always_ff @(posedge clk) begin
    if (!rst || clear_edge || cur_st == ST_IDLE) begin
      presc <= '0;
    end else if (cur_st == ST_RUN) begin
      presc <= (presc == PS_MAX) ? '0 : presc + PW'(1);
    end
  end

  // Lap capture in RUN/PAUSE; a coincident clear still captures the pre-clear digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_l     <= 4'd0;
      lap_h     <= 4'd0;
      lap_valid <= 1'b0;
    end else if (lap_edge && (cur_st == ST_RUN || cur_st == ST_PAUSE)) begin
      lap_l     <= cnt_digit_l;
      lap_h     <= cnt_digit_h;
      lap_valid <= 1'b1;
    end else begin
      lap_valid <= 1'b0;
    end
  end

  // Tick is low for the first half of each period.
  assign cnt_clk_1hz = (presc >= PS_HALF);
  assign state       = cur_st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: two controllers (halt-at-wrap and run-through) with a BCD counter model each,
// sharing the same clock, reset and buttons. DIV = 8.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_run;
  logic btn_clear;
  logic btn_lap;

  logic [3:0] dl [2];
  logic [3:0] dh [2];
  logic       ovf [2];
  logic       tick_d [2];
  logic       crst [2];
  logic       ctick [2];
  logic       cstart [2];
  logic       cpause [2];
  logic [3:0] lapl [2];
  logic [3:0] laph [2];
  logic       lapv [2];
  logic       alm [2];
  logic [1:0] st [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(8), .TICK_HZ(1), .STOP_AT_WRAP(1'b1)) u_halt (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cnt_digit_l(dl[0]), .cnt_digit_h(dh[0]), .cnt_overflow(ovf[0]),
    .cnt_rst(crst[0]), .cnt_clk_1hz(ctick[0]), .cnt_start(cstart[0]), .cnt_pause(cpause[0]),
    .lap_l(lapl[0]), .lap_h(laph[0]), .lap_valid(lapv[0]), .alarm(alm[0]), .state(st[0])
  );

  stopwatch_ctrl #(.CLK_HZ(8), .TICK_HZ(1), .STOP_AT_WRAP(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cnt_digit_l(dl[1]), .cnt_digit_h(dh[1]), .cnt_overflow(ovf[1]),
    .cnt_rst(crst[1]), .cnt_clk_1hz(ctick[1]), .cnt_start(cstart[1]), .cnt_pause(cpause[1]),
    .lap_l(lapl[1]), .lap_h(laph[1]), .lap_valid(lapv[1]), .alarm(alm[1]), .state(st[1])
  );

  // Counter model: counts on each rising tick while enabled and not paused.
  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always @(posedge clk) begin
      tick_d[g] <= ctick[g];
      ovf[g]    <= 1'b0;
      if (crst[g]) begin
        dl[g] <= 4'd0;
        dh[g] <= 4'd0;
      end else if (ctick[g] && !tick_d[g] && cstart[g] && !cpause[g]) begin
        if (dl[g] == 4'd9) begin
          dl[g] <= 4'd0;
          if (dh[g] == 4'd9) begin
            dh[g]  <= 4'd0;
            ovf[g] <= 1'b1;
          end else begin
            dh[g] <= dh[g] + 4'd1;
          end
        end else begin
          dl[g] <= dl[g] + 4'd1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle press; returns one cycle after the resulting state change.
  task automatic press_run();
    btn_run = 1'b1;
    cyc(1);
    btn_run = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst = 1'b0; btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    cyc(3);
    chk("rst_state",  32'(st[0]), 32'd0);
    chk("rst_cntrst", 32'(crst[0]), 32'd1);
    chk("rst_start",  32'(cstart[0]), 32'd0);
    chk("rst_pause",  32'(cpause[0]), 32'd0);
    chk("rst_tick",   32'(ctick[0]), 32'd0);
    chk("rst_alarm",  32'(alm[0]), 32'd0);
    chk("rst_lap",    32'({laph[0], lapl[0]}), 32'h00);
    chk("rst_lapv",   32'(lapv[0]), 32'd0);
    rst = 1'b1;
    cyc(1);                                   // P0+1
    // Start: RUN two cycles after the first sampled edge.
    btn_run = 1'b1;
    cyc(2);                                   // P2+1
    chk("start_not_yet", 32'(st[0]), 32'd0);
    cyc(1);                                   // P3+1
    chk("start_run", 32'(st[0]), 32'd1);
    chk("start_tick0", 32'(ctick[0]), 32'd0);
    btn_run = 1'b0;
    cyc(3);                                   // P6+1
    chk("tick_low_p6", 32'(ctick[0]), 32'd0);
    cyc(1);                                   // P7+1
    chk("tick_first_rise", 32'(ctick[0]), 32'd1);
    cyc(17);                                  // P24+1
    chk("digits_03", 32'({dh[0], dl[0]}), 32'h03);
    // Pause at 05 with two prescaler counts into the second.
    cyc(18);                                  // P42+1
    chk("digits_05", 32'({dh[0], dl[0]}), 32'h05);
    btn_run = 1'b1;
    cyc(2);                                   // P44+1
    btn_run = 1'b0;
    chk("pause_not_yet", 32'(st[0]), 32'd1);
    cyc(1);                                   // P45+1
    chk("pause_state", 32'(st[0]), 32'd2);
    chk("pause_ctl", 32'({cstart[0], cpause[0]}), 32'b11);
    cyc(100);                                 // P145+1
    chk("pause_hold_05", 32'({dh[0], dl[0]}), 32'h05);
    chk("pause_tick", 32'(ctick[0]), 32'd0);
    // Resume: tick rises after the remaining 2 counts, not 4.
    btn_run = 1'b1;
    cyc(3);                                   // P148+1
    btn_run = 1'b0;
    chk("resume_run", 32'(st[0]), 32'd1);
    chk("resume_tick0", 32'(ctick[0]), 32'd0);
    cyc(1);                                   // P149+1
    chk("resume_tick_p149", 32'(ctick[0]), 32'd0);
    cyc(1);                                   // P150+1
    chk("resume_tick_rise", 32'(ctick[0]), 32'd1);
    cyc(1);                                   // P151+1
    chk("digits_06", 32'({dh[0], dl[0]}), 32'h06);
    // Lap at 12.
    cyc(48);                                  // P199+1
    chk("digits_12", 32'({dh[0], dl[0]}), 32'h12);
    btn_lap = 1'b1;
    cyc(2);                                   // P201+1
    btn_lap = 1'b0;
    chk("lap_not_yet", 32'(lapv[0]), 32'd0);
    cyc(1);                                   // P202+1
    chk("lap_pulse", 32'(lapv[0]), 32'd1);
    chk("lap_digits", 32'({laph[0], lapl[0]}), 32'h12);
    cyc(1);                                   // P203+1
    chk("lap_one_cycle", 32'(lapv[0]), 32'd0);
    chk("lap_held", 32'({laph[0], lapl[0]}), 32'h12);
    // Wrap at 99.
    cyc(699);                                 // P902+1
    chk("digits_99", 32'({dh[0], dl[0]}), 32'h99);
    chk("run_at_99", 32'(st[0]), 32'd1);
    cyc(1);                                   // P903+1
    chk("digits_00", 32'({dh[0], dl[0]}), 32'h00);
    cyc(1);                                   // P904+1
    chk("halt_done", 32'(st[0]), 32'd3);
    chk("halt_alarm", 32'(alm[0]), 32'd1);
    chk("halt_digits", 32'({dh[0], dl[0]}), 32'h00);
    chk("wrap_still_run", 32'(st[1]), 32'd1);
    chk("wrap_alarm", 32'(alm[1]), 32'd0);
    chk("wrap_digits", 32'({dh[1], dl[1]}), 32'h00);
    // Run press ignored in DONE.
    btn_run = 1'b1;
    cyc(3);                                   // P907+1
    btn_run = 1'b0;
    chk("done_ignore_run", 32'(st[0]), 32'd3);
    chk("done_alarm_kept", 32'(alm[0]), 32'd1);
    chk("wrap_paused", 32'(st[1]), 32'd2);
    // Clear leaves DONE.
    btn_clear = 1'b1;
    cyc(2);                                   // P909+1
    chk("clear_not_yet", 32'(st[0]), 32'd3);
    cyc(1);                                   // P910+1
    btn_clear = 1'b0;
    chk("clear_idle", 32'(st[0]), 32'd0);
    chk("clear_alarm", 32'(alm[0]), 32'd0);
    chk("clear_cntrst", 32'(crst[0]), 32'd1);
    chk("clear_tick", 32'(ctick[0]), 32'd0);
    // Lap in IDLE is ignored.
    btn_lap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("idle_lap_none", 32'(lapv[0]), 32'd0);
    end
    btn_lap = 1'b0;
    chk("idle_lap_kept", 32'({laph[0], lapl[0]}), 32'h12);
    cyc(2);
    // Clear and run together in PAUSE -> IDLE.
    press_run();
    chk("seq_run", 32'(st[0]), 32'd1);
    press_run();
    chk("seq_pause", 32'(st[0]), 32'd2);
    btn_clear = 1'b1;
    btn_run   = 1'b1;
    cyc(1);
    btn_clear = 1'b0;
    btn_run   = 1'b0;
    cyc(2);
    chk("clear_beats_run", 32'(st[0]), 32'd0);
    chk("clear_beats_run_rst", 32'(crst[0]), 32'd1);
    // Reset mid-run.
    press_run();
    chk("rerun", 32'(st[0]), 32'd1);
    cyc(10);
    rst = 1'b0;
    cyc(1);
    chk("midrst_state", 32'(st[0]), 32'd0);
    chk("midrst_cntrst", 32'(crst[0]), 32'd1);
    chk("midrst_start", 32'(cstart[0]), 32'd0);
    chk("midrst_lap", 32'({laph[0], lapl[0]}), 32'h00);
    chk("midrst_lapv", 32'(lapv[0]), 32'd0);
    chk("midrst_tick", 32'(ctick[0]), 32'd0);
    rst = 1'b1;
    cyc(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
